mult_cdb_buffer: RTL

- Completion buffer directly downstream of the two-lane pipelined multiplier unit.
- Captures up to two multiply results per cycle and holds them in order until the CDB arbiter grants broadcast slots.
- The multiplier pipeline cannot stall, so the block issues credits back to the RS. An instruction is only issued when buffer space is guaranteed at completion.

---
 rtl/mult_cdb_buffer_pkg.sv | 17 +
 rtl/mult_cdb_buffer_if.sv | 42 ++++
 rtl/mult_cdb_buffer_credit.sv | 58 +++++
 rtl/mult_cdb_buffer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mult_cdb_buffer_pkg.sv
// Shared types and constants for the multiplier completion buffer.
// Provides the CDB entry record, the default depth and the `SD delay macro.
`ifndef SD
`define SD
`endif

package mult_cdb_buffer_pkg;

    localparam int DEFAULT_DEPTH = 8;

    typedef struct packed {
        logic [4:0]  ar_idx;
        logic [6:0]  pr_idx;
        logic [63:0] result;
    } cdb_entry_t;

endpackage

// File: rtl/mult_cdb_buffer_if.sv
// Bus between the multiplier/RS/CDB arbiter and the completion buffer.
// The slave modport is the buffer's view; master is the surrounding pipeline.
interface mult_cdb_buffer_if;
    logic [1:0]  rs_issue;
    logic [1:0]  mul_complete;
    logic [4:0]  mul_dest_ar_idx0;
    logic [4:0]  mul_dest_ar_idx1;
    logic [6:0]  mul_dest_pr_idx0;
    logic [6:0]  mul_dest_pr_idx1;
    logic [63:0] mul_result0;
    logic [63:0] mul_result1;
    logic [1:0]  cdb_grant;
    logic [1:0]  cdb_valid;
    logic [4:0]  cdb_dest_ar_idx0;
    logic [4:0]  cdb_dest_ar_idx1;
    logic [6:0]  cdb_dest_pr_idx0;
    logic [6:0]  cdb_dest_pr_idx1;
    logic [63:0] cdb_result0;
    logic [63:0] cdb_result1;
    logic [1:0]  rs_mult_avail;
    logic        overflow_err;

    modport slave (
        input  rs_issue, mul_complete,
        input  mul_dest_ar_idx0, mul_dest_ar_idx1,
        input  mul_dest_pr_idx0, mul_dest_pr_idx1,
        input  mul_result0, mul_result1, cdb_grant,
        output cdb_valid, cdb_dest_ar_idx0, cdb_dest_ar_idx1,
        output cdb_dest_pr_idx0, cdb_dest_pr_idx1,
        output cdb_result0, cdb_result1, rs_mult_avail, overflow_err
    );

    modport master (
        output rs_issue, mul_complete,
        output mul_dest_ar_idx0, mul_dest_ar_idx1,
        output mul_dest_pr_idx0, mul_dest_pr_idx1,
        output mul_result0, mul_result1, cdb_grant,
        input  cdb_valid, cdb_dest_ar_idx0, cdb_dest_ar_idx1,
        input  cdb_dest_pr_idx0, cdb_dest_pr_idx1,
        input  cdb_result0, cdb_result1, rs_mult_avail, overflow_err
    );
endinterface

// File: rtl/mult_cdb_buffer_credit.sv
// Issue-credit tracker: counts multiplies in flight and grants RS credits only
// when a buffer slot is guaranteed at completion time.
module mult_buf_credit
    import mult_cdb_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] i_count,
    input  logic [1:0]       i_rs_issue,
    input  logic [1:0]       i_mul_complete,
    output logic [1:0]       o_rs_mult_avail,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_inflight;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W:0]   w_done;
    logic [CNT_W:0]   w_total;
    logic [CNT_W:0]   w_free;
    logic [1:0]       w_n_issue;
    logic [1:0]       w_n_done;

    assign w_n_issue = {1'b0, i_rs_issue[0]} + {1'b0, i_rs_issue[1]};
    assign w_n_done  = {1'b0, i_mul_complete[0]} + {1'b0, i_mul_complete[1]};
    assign w_sum     = {1'b0, r_inflight} + (CNT_W+1)'(w_n_issue);
    assign w_done    = (CNT_W+1)'(w_n_done);

    // A completion with nothing in flight is a bookkeeping error: clamp at zero.
    assign o_underflow = (w_sum < w_done);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_inflight <= '0;
        end else if (o_underflow) begin
            r_inflight <= '0;
        end else begin
            r_inflight <= CNT_W'(w_sum - w_done);
        end
    end

    assign w_total = {1'b0, i_count} + {1'b0, r_inflight};
    assign w_free  = (w_total >= (CNT_W+1)'(DEPTH)) ? '0 : (CNT_W+1)'(DEPTH) - w_total;

    always_comb begin
        o_rs_mult_avail = 2'b00;
        if (reset) begin
            if (w_free >= (CNT_W+1)'(2)) begin
                o_rs_mult_avail = 2'b11;
            end else if (w_free == (CNT_W+1)'(1)) begin
                o_rs_mult_avail = 2'b01;
            end
        end
    end

endmodule

// File: rtl/mult_cdb_buffer.sv
// In-order two-lane completion buffer between the multiplier and the CDB.
// Optional macro MULT_BUF_BYPASS_EN forwards completions straight to the CDB when empty.
module mult_cdb_buffer
    import mult_cdb_buffer_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clock,
    input  logic               reset,
    mult_cdb_buffer_if.slave   bus
);

    cdb_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    cdb_entry_t       w_lane0, w_lane1;
    cdb_entry_t       w_slot0, w_slot1;
    cdb_entry_t       w_out0, w_out1;
    logic [PTR_W-1:0] w_head1;
    logic [PTR_W-1:0] w_ptr1;
    logic [1:0]       w_sto_valid;
    logic [1:0]       w_out_valid;
    logic             w_byp;
    logic [1:0]       w_byp_taken;
    logic [1:0]       w_enq_req;
    logic [1:0]       w_acc;
    logic [1:0]       w_deq;
    logic [1:0]       w_n_acc;
    logic [CNT_W-1:0] w_space;
    logic             w_drop;
    logic             w_underflow;

    assign w_lane0 = '{ar_idx: bus.mul_dest_ar_idx0, pr_idx: bus.mul_dest_pr_idx0,
                       result: bus.mul_result0};
    assign w_lane1 = '{ar_idx: bus.mul_dest_ar_idx1, pr_idx: bus.mul_dest_pr_idx1,
                       result: bus.mul_result1};

    assign w_head1        = r_head + PTR_W'(1);
    assign w_slot0        = r_mem[r_head];
    assign w_slot1        = r_mem[w_head1];
    assign w_sto_valid[0] = (r_count >= CNT_W'(1));
    assign w_sto_valid[1] = (r_count >= CNT_W'(2));

`ifdef MULT_BUF_BYPASS_EN
    assign w_byp = reset && (r_count == '0) && bus.mul_complete[0];
`else
    assign w_byp = 1'b0;
`endif

    assign w_out_valid[0] = w_byp ? 1'b1 : w_sto_valid[0];
    assign w_out_valid[1] = w_byp ? bus.mul_complete[1] : w_sto_valid[1];
    assign w_out0         = w_byp ? w_lane0 : w_slot0;
    assign w_out1         = w_byp ? w_lane1 : w_slot1;

    // Granted bypassed lanes leave directly; everything else must be stored.
    assign w_byp_taken[0] = w_byp && bus.cdb_grant[0];
    assign w_byp_taken[1] = w_byp && bus.mul_complete[1] && bus.cdb_grant[0] && bus.cdb_grant[1];
    assign w_enq_req      = bus.mul_complete & ~w_byp_taken;

    always_comb begin
        w_deq = 2'd0;
        if (bus.cdb_grant[0] && w_sto_valid[0]) begin
            w_deq = 2'd1;
            if (bus.cdb_grant[1] && w_sto_valid[1]) begin
                w_deq = 2'd2;
            end
        end
        // Slots freed by this cycle's dequeue are reusable by this cycle's enqueue.
        w_space = CNT_W'(DEPTH) - r_count + CNT_W'(w_deq);
        w_acc   = 2'b00;
        if (w_enq_req[0] && (w_space != '0)) begin
            w_acc[0] = 1'b1;
        end
        if (w_enq_req[1] && (w_space > CNT_W'(w_acc[0]))) begin
            w_acc[1] = 1'b1;
        end
        w_drop  = |(w_enq_req & ~w_acc);
        w_ptr1  = r_tail + PTR_W'(w_acc[0]);
        w_n_acc = {1'b0, w_acc[0]} + {1'b0, w_acc[1]};
    end

    always_ff @(posedge clock) begin
        if (reset && w_acc[0]) begin
            r_mem[r_tail] <= w_lane0;
        end
        if (reset && w_acc[1]) begin
            r_mem[w_ptr1] <= w_lane1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_head  <= r_head + PTR_W'(w_deq);
            r_tail  <= r_tail + PTR_W'(w_n_acc);
            r_count <= r_count + CNT_W'(w_n_acc) - CNT_W'(w_deq);
            if (w_drop || w_underflow) begin
                r_overflow <= 1'b1;
            end
        end
    end

    mult_buf_credit #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_credit (
        .clock           (clock),
        .reset           (reset),
        .i_count         (r_count),
        .i_rs_issue      (bus.rs_issue),
        .i_mul_complete  (bus.mul_complete),
        .o_rs_mult_avail (bus.rs_mult_avail),
        .o_underflow     (w_underflow)
    );

    assign bus.cdb_valid        = w_out_valid;
    assign bus.cdb_dest_ar_idx0 = w_out0.ar_idx;
    assign bus.cdb_dest_ar_idx1 = w_out1.ar_idx;
    assign bus.cdb_dest_pr_idx0 = w_out0.pr_idx;
    assign bus.cdb_dest_pr_idx1 = w_out1.pr_idx;
    assign bus.cdb_result0      = w_out0.result;
    assign bus.cdb_result1      = w_out1.result;
    assign bus.overflow_err     = r_overflow;

endmodule
